// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: walks a program in synchronous RAM and issues one instruction at a time.
// Optional watchdog on WAIT_EXEC is built when IFETCH_TIMEOUT_EN is defined.
module instruction_fetch #(
  parameter int ADDR_W         = 8,
  parameter int INSTR_W        = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  instr_count,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_enable,
  input  logic               exec_done,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_DATA,
    WAIT_EXEC,
    FINISH
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   remaining;
  logic [7:0]          opcode;
  logic                load;
  logic                advance;
  logic                issue;
  logic                exec_ack;
  logic                timeout;

  assign opcode = imem_rdata[INSTR_W-1 -: 8];

  // The issue cycle is already WAIT_EXEC; a completion pulse there belongs to nothing.
  assign exec_ack = (state == WAIT_EXEC) && exec_done && !instr_enable;

  assign imem_rd_en = (state == READ);
  assign imem_addr  = pc;
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (instr_count == '0) ? FINISH : READ;
        end
      end
      READ: begin
        state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (opcode == OP_HALT) begin
          state_nxt = FINISH;
        end else if (opcode == OP_NOP) begin
          advance   = 1'b1;
          state_nxt = (remaining == ADDR_W'(1)) ? FINISH : READ;
        end else begin
          issue     = 1'b1;
          state_nxt = WAIT_EXEC;
        end
      end
      WAIT_EXEC: begin
        if (exec_ack) begin
          advance   = 1'b1;
          state_nxt = (remaining == ADDR_W'(1)) ? FINISH : READ;
        end else if (timeout) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= '0;
      remaining    <= '0;
      instruction  <= '0;
      instr_enable <= 1'b0;
    end else begin
      instr_enable <= issue;
      if (issue) begin
        instruction <= imem_rdata;
      end
      if (load) begin
        pc        <= base_addr;
        remaining <= instr_count;
      end else if (advance) begin
        pc        <= pc + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
      end
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt;

  assign timeout = (state == WAIT_EXEC) && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (issue) begin
      wd_cnt <= '0;
    end else if (state == WAIT_EXEC) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else if (load) begin
      error <= 1'b0;
    end else if (timeout && !exec_ack) begin
      error <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule
